md_seq: RTL

//   Sequencer for the shared multiply/divide resource in the EX stage. Latches an

---
 rtl/md_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/md_seq.sv
// ============================================================================
// Module   : md_seq
// Brief    : Multiply/divide sequencer owning HI/LO, with fixed-latency busy
//            window and ID-stage stall generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_seq #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        id_hilo,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             divz_q, divz_d;

    logic [63:0]      w_smul;
    logic [63:0]      w_umul;
    logic [31:0]      w_div_b;
    logic [31:0]      w_squo;
    logic [31:0]      w_srem;
    logic [31:0]      w_uquo;
    logic [31:0]      w_urem;
    logic             w_md_issue;

    // Sign/zero-extend to 64 bits so the low 64 product bits are exact.
    assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_umul = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced so the dividers never see x; the result is discarded anyway.
    assign w_div_b = (B == 32'd0) ? 32'd1 : B;
    assign w_squo  = $signed(A) / $signed(w_div_b);
    assign w_srem  = $signed(A) % $signed(w_div_b);
    assign w_uquo  = A / w_div_b;
    assign w_urem  = A % w_div_b;

    assign w_md_issue = start && (op >= 3'd1) && (op <= 3'd4);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        divz_d    = divz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'd1: begin
                            {pend_hi_d, pend_lo_d} = w_smul;
                            divz_d  = 1'b0;
                            cnt_d   = c_mult_cnt;
                            state_d = ST_BUSY;
                        end
                        3'd2: begin
                            {pend_hi_d, pend_lo_d} = w_umul;
                            divz_d  = 1'b0;
                            cnt_d   = c_mult_cnt;
                            state_d = ST_BUSY;
                        end
                        3'd3: begin
                            pend_lo_d = w_squo;
                            pend_hi_d = w_srem;
                            divz_d    = (B == 32'd0);
                            cnt_d     = c_div_cnt;
                            state_d   = ST_BUSY;
                        end
                        3'd4: begin
                            pend_lo_d = w_uquo;
                            pend_hi_d = w_urem;
                            divz_d    = (B == 32'd0);
                            cnt_d     = c_div_cnt;
                            state_d   = ST_BUSY;
                        end
                        3'd5:    hi_d = A;
                        3'd6:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == c_cnt_one) begin
                    if (!divz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            divz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            divz_q    <= divz_d;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    // The issue term covers the cycle the op is in EX before busy rises.
    assign md_stall = id_hilo && (busy || w_md_issue);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

`default_nettype wire
